// File: rtl/vga_pattern_timing.sv
// VGA timing generator with built-in test patterns (bars, grid, scroll, solid green).
// All outputs registered, 1 clk_pixel latency behind the counters; free-running, no backpressure.
module vga_pattern_timing #(
    parameter int   C_resolution_x      = 640,
    parameter int   C_hsync_front_porch = 16,
    parameter int   C_hsync_pulse       = 96,
    parameter int   C_hsync_back_porch  = 48,
    parameter int   C_resolution_y      = 480,
    parameter int   C_vsync_front_porch = 10,
    parameter int   C_vsync_pulse       = 2,
    parameter int   C_vsync_back_porch  = 33,
    parameter logic C_sync_polarity     = 1'b0,
    parameter int   C_depth             = 3
) (
    input  logic               clk_pixel,
    input  logic               resetn,
    input  logic [1:0]         mode,
    output logic [C_depth-1:0] red_p,
    output logic [C_depth-1:0] green_p,
    output logic [C_depth-1:0] blue_p,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               frame_start
);

    localparam int H_TOT = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOT = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
    localparam int CW    = 12;
    localparam int BAR_W = C_resolution_x / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] RX       = CW'(C_resolution_x);
    localparam logic [CW-1:0] RY       = CW'(C_resolution_y);
    localparam logic [CW-1:0] RX_LAST  = CW'(C_resolution_x - 1);
    localparam logic [CW-1:0] RY_LAST  = CW'(C_resolution_y - 1);
    localparam logic [CW-1:0] HS_START = CW'(C_resolution_x + C_hsync_front_porch);
    localparam logic [CW-1:0] HS_END   = CW'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [CW-1:0] VS_START = CW'(C_resolution_y + C_vsync_front_porch);
    localparam logic [CW-1:0] VS_END   = CW'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic [7:0]    frame;
    logic [1:0]    mode_q;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;

    logic h_last;
    logic v_last;
    logic at_origin;
    logic visible;
    logic hs_act;
    logic vs_act;
    logic grid_on;
    logic [1:0] mode_eff;
    logic [7:0] scroll_sum;

    assign h_last    = (hcount == H_LAST);
    assign v_last    = (vcount == V_LAST);
    assign at_origin = (hcount == '0) && (vcount == '0);
    assign visible   = (hcount < RX) && (vcount < RY);
    assign hs_act    = (hcount >= HS_START) && (hcount < HS_END);
    assign vs_act    = (vcount >= VS_START) && (vcount < VS_END);
    assign grid_on   = (hcount[4:0] == 5'd0) || (vcount[4:0] == 5'd0)
                    || (hcount == RX_LAST) || (vcount == RY_LAST);

    // The pixel at (0,0) already uses the mode being latched, so a new mode
    // takes effect cleanly from the first pixel of a frame.
    assign mode_eff   = at_origin ? mode : mode_q;
    assign scroll_sum = {2'b00, hcount[9:4]} + frame;

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            hcount <= '0;
            vcount <= '0;
            frame  <= '0;
            mode_q <= '0;
        end else begin
            if (h_last) begin
                hcount <= '0;
                if (v_last) begin
                    vcount <= '0;
                    frame  <= frame + 1'b1;
                end else begin
                    vcount <= vcount + 1'b1;
                end
            end else begin
                hcount <= hcount + 1'b1;
            end
            if (at_origin) begin
                mode_q <= mode;
            end
        end
    end

    // Bar index tracks hcount / BAR_W incrementally instead of dividing.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_last) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 1'b1;
        end else begin
            bar_px  <= bar_px + 1'b1;
        end
    end

    logic [C_depth-1:0] red_n;
    logic [C_depth-1:0] green_n;
    logic [C_depth-1:0] blue_n;

    always_comb begin
        red_n   = '0;
        green_n = '0;
        blue_n  = '0;
        if (visible) begin
            case (mode_eff)
                2'd0: begin
                    red_n   = {C_depth{bar_idx[2]}};
                    green_n = {C_depth{bar_idx[1]}};
                    blue_n  = {C_depth{bar_idx[0]}};
                end
                2'd1: begin
                    if (grid_on) begin
                        red_n   = '1;
                        green_n = '1;
                        blue_n  = '1;
                    end
                end
                2'd2: begin
                    red_n   = scroll_sum[C_depth-1:0];
                    green_n = vcount[C_depth+3:4];
                    blue_n  = frame[C_depth-1:0];
                end
                default: begin
                    green_n = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            red_p       <= '0;
            green_p     <= '0;
            blue_p      <= '0;
            hsync       <= ~C_sync_polarity;
            vsync       <= ~C_sync_polarity;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            red_p       <= red_n;
            green_p     <= green_n;
            blue_p      <= blue_n;
            hsync       <= C_sync_polarity ? hs_act : ~hs_act;
            vsync       <= C_sync_polarity ? vs_act : ~vs_act;
            blank       <= ~visible;
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_pattern_timing.sv
// Bench: three instances (full 640x480, shrunken timing, shrunken with active-high sync)
// compared every cycle against an arithmetic model of position, sync windows and patterns.
module tb_vga_pattern_timing;

    localparam int D = 3;
    localparam int BRX = 640, BHF = 16, BHS = 96, BHB = 48, BRY = 480, BVF = 10, BVS = 2, BVB = 33;
    localparam int SRX = 24,  SHF = 2,  SHS = 3,  SHB = 3,  SRY = 4,   SVF = 1,  SVS = 2, SVB = 1;
    localparam int BHT = BRX + BHF + BHS + BHB;
    localparam int BVT = BRY + BVF + BVS + BVB;
    localparam int SHT = SRX + SHF + SHS + SHB;
    localparam int SVT = SRY + SVF + SVS + SVB;
    localparam int BFR = BHT * BVT;
    localparam int SFR = SHT * SVT;

    logic clk_pixel = 1'b0;
    logic resetn    = 1'b0;
    logic [1:0] mode = 2'd3;

    logic [D-1:0] r_b, g_b, b_b, r_s, g_s, b_s, r_p, g_p, b_p;
    logic hs_b, vs_b, bl_b, fs_b, hs_s, vs_s, bl_s, fs_s, hs_p, vs_p, bl_p, fs_p;

    always #5 clk_pixel = ~clk_pixel;

    vga_pattern_timing #(
        .C_resolution_x(BRX), .C_hsync_front_porch(BHF), .C_hsync_pulse(BHS), .C_hsync_back_porch(BHB),
        .C_resolution_y(BRY), .C_vsync_front_porch(BVF), .C_vsync_pulse(BVS), .C_vsync_back_porch(BVB),
        .C_sync_polarity(1'b0), .C_depth(D)
    ) dut_big (
        .clk_pixel(clk_pixel), .resetn(resetn), .mode(mode),
        .red_p(r_b), .green_p(g_b), .blue_p(b_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_start(fs_b)
    );

    vga_pattern_timing #(
        .C_resolution_x(SRX), .C_hsync_front_porch(SHF), .C_hsync_pulse(SHS), .C_hsync_back_porch(SHB),
        .C_resolution_y(SRY), .C_vsync_front_porch(SVF), .C_vsync_pulse(SVS), .C_vsync_back_porch(SVB),
        .C_sync_polarity(1'b0), .C_depth(D)
    ) dut_small (
        .clk_pixel(clk_pixel), .resetn(resetn), .mode(mode),
        .red_p(r_s), .green_p(g_s), .blue_p(b_s),
        .hsync(hs_s), .vsync(vs_s), .blank(bl_s), .frame_start(fs_s)
    );

    vga_pattern_timing #(
        .C_resolution_x(SRX), .C_hsync_front_porch(SHF), .C_hsync_pulse(SHS), .C_hsync_back_porch(SHB),
        .C_resolution_y(SRY), .C_vsync_front_porch(SVF), .C_vsync_pulse(SVS), .C_vsync_back_porch(SVB),
        .C_sync_polarity(1'b1), .C_depth(D)
    ) dut_pol (
        .clk_pixel(clk_pixel), .resetn(resetn), .mode(mode),
        .red_p(r_p), .green_p(g_p), .blue_p(b_p),
        .hsync(hs_p), .vsync(vs_p), .blank(bl_p), .frame_start(fs_p)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector {frame_start, blank, hsync, vsync, red, green, blue} for the
    // counter position reached after s clocks since reset release.
    function automatic logic [12:0] model(input int s, input int md,
                                          input int rx, input int hf, input int hsw, input int hb,
                                          input int ry, input int vf, input int vsw, input int vb,
                                          input logic pol);
        int ht, vt, h, v, fr, bar;
        logic vis, hsa, vsa;
        logic [2:0] r, g, b;
        ht = rx + hf + hsw + hb;
        vt = ry + vf + vsw + vb;
        h  = s % ht;
        v  = (s / ht) % vt;
        fr = (s / (ht * vt)) % 256;
        vis = (h < rx) && (v < ry);
        hsa = (h >= rx + hf) && (h < rx + hf + hsw);
        vsa = (v >= ry + vf) && (v < ry + vf + vsw);
        r = 3'd0; g = 3'd0; b = 3'd0;
        if (vis) begin
            case (md)
                0: begin
                    bar = h / (rx / 8);
                    r = ((bar & 4) != 0) ? 3'd7 : 3'd0;
                    g = ((bar & 2) != 0) ? 3'd7 : 3'd0;
                    b = ((bar & 1) != 0) ? 3'd7 : 3'd0;
                end
                1: begin
                    if (h % 32 == 0 || v % 32 == 0 || h == rx - 1 || v == ry - 1) begin
                        r = 3'd7; g = 3'd7; b = 3'd7;
                    end
                end
                2: begin
                    r = 3'((h / 16 + fr) % 8);
                    g = 3'((v / 16) % 8);
                    b = 3'(fr % 8);
                end
                default: g = 3'd7;
            endcase
        end
        return {(h == 0 && v == 0), !vis, hsa ? pol : !pol, vsa ? pol : !pol, r, g, b};
    endfunction

    function automatic logic [12:0] rst_out(input logic pol);
        return {1'b0, 1'b1, !pol, !pol, 9'd0};
    endfunction

    int s = 0;
    int mq_b = 0, mq_s = 0;
    logic [12:0] exp_b, exp_s, exp_p;
    int bg_run = 0, bg_per = 0, sm_per = 0, sm_vis = 0, sm_vs = 0;
    bit bg_have = 0, sm_have = 0;

    function automatic logic [12:0] obs_big();
        return {fs_b, bl_b, hs_b, vs_b, r_b, g_b, b_b};
    endfunction
    function automatic logic [12:0] obs_small();
        return {fs_s, bl_s, hs_s, vs_s, r_s, g_s, b_s};
    endfunction
    function automatic logic [12:0] obs_pol();
        return {fs_p, bl_p, hs_p, vs_p, r_p, g_p, b_p};
    endfunction

    task automatic step();
        @(posedge clk_pixel);
        if (resetn) begin
            if (s % BFR == 0) mq_b = int'(mode);
            if (s % SFR == 0) mq_s = int'(mode);
            exp_b = model(s, mq_b, BRX, BHF, BHS, BHB, BRY, BVF, BVS, BVB, 1'b0);
            exp_s = model(s, mq_s, SRX, SHF, SHS, SHB, SRY, SVF, SVS, SVB, 1'b0);
            exp_p = model(s, mq_s, SRX, SHF, SHS, SHB, SRY, SVF, SVS, SVB, 1'b1);
            s++;
        end else begin
            exp_b = rst_out(1'b0);
            exp_s = rst_out(1'b0);
            exp_p = rst_out(1'b1);
            s = 0;
        end
        @(negedge clk_pixel);
        chk("big_out", 32'(obs_big()), 32'(exp_b));
        chk("small_out", 32'(obs_small()), 32'(exp_s));
        chk("pol1_out", 32'(obs_pol()), 32'(exp_p));
        if (!resetn) begin
            bg_run = 0; bg_per = 0; bg_have = 0; sm_have = 0;
        end else begin
            bg_per++;
            if (!hs_b) begin
                if (bg_run == 0) begin
                    chk("big_hsync_start", 32'((s - 1) % BHT), 32'(BRX + BHF));
                    if (bg_have) chk("big_line_period", 32'(bg_per), 32'(BHT));
                    bg_have = 1; bg_per = 0;
                end
                bg_run++;
            end else if (bg_run != 0) begin
                chk("big_hsync_width", 32'(bg_run), 32'(BHS));
                bg_run = 0;
            end
            if (fs_s) begin
                if (sm_have) begin
                    chk("small_frame_period", 32'(sm_per), 32'(SFR));
                    chk("small_visible_cnt", 32'(sm_vis), 32'(SRX * SRY));
                    chk("small_vsync_cnt", 32'(sm_vs), 32'(SVS * SHT));
                end
                sm_have = 1; sm_per = 0; sm_vis = 0; sm_vs = 0;
            end
            sm_per++;
            if (!bl_s) sm_vis++;
            if (!vs_s) sm_vs++;
        end
    endtask

    initial begin
        int cnt;
        resetn = 1'b0;
        mode   = 2'd3;
        for (int i = 0; i < 4; i++) step();

        // Release with solid green: first output carries pixel (0,0).
        resetn = 1'b1;
        step();
        chk("first_edge", 32'({fs_b, bl_b, r_b, g_b, b_b}), 32'({1'b1, 1'b0, 9'o070}));
        for (int i = 0; i < 2 * BHT && errors < 200; i++) step();

        // Asynchronous reset mid-line, checked before the next clock edge.
        resetn = 1'b0;
        mode   = 2'd0;
        #1;
        chk("async_rst_big", 32'(obs_big()), 32'(rst_out(1'b0)));
        chk("async_rst_small", 32'(obs_small()), 32'(rst_out(1'b0)));
        chk("async_rst_pol1", 32'(obs_pol()), 32'(rst_out(1'b1)));
        for (int i = 0; i < 3; i++) step();

        // Colour bars on the full-size timing.
        resetn = 1'b1;
        for (int i = 0; i < 2 * BHT && errors < 200; i++) begin
            step();
            if (s - 1 == 0)   chk("bar_px0",   32'({bl_b, r_b, g_b, b_b}), 32'({1'b0, 9'o000}));
            if (s - 1 == 80)  chk("bar_px80",  32'({bl_b, r_b, g_b, b_b}), 32'({1'b0, 9'o007}));
            if (s - 1 == 560) chk("bar_px560", 32'({bl_b, r_b, g_b, b_b}), 32'({1'b0, 9'o777}));
            if (s - 1 == 640) chk("bar_px640", 32'({bl_b, r_b, g_b, b_b}), 32'({1'b1, 9'o000}));
        end

        // Reset again, then random mode changes over more than 256 small frames.
        @(negedge clk_pixel);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) step();
        resetn = 1'b1;
        cnt = 0;
        while (s < 257 * SFR + 100 && errors < 200) begin
            if (s > 240 * SFR) begin
                mode = 2'd2;
            end else if (cnt == 0) begin
                mode = 2'($urandom_range(0, 3));
                cnt  = $urandom_range(20, 600);
            end else begin
                cnt--;
            end
            step();
            if (s - 1 == 255 * SFR) chk("wrap_pre", 32'({fs_s, b_s}), 32'({1'b1, 3'd7}));
            if (s - 1 == 256 * SFR) chk("wrap_post", 32'({fs_s, b_s}), 32'({1'b1, 3'd0}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
